// File: rtl/key_event_decoder_pkg.sv
// -----------------------------------------------------------------------------
// key_evt_pkg
// Shared definitions for the key event decoder slice:
//   - CNT_W            : width of the single state-timing counter
//   - *_DEF            : default timing values in clk cycles (50 MHz clock)
//   - key_state_t      : FSM state encoding
// Optional feature macro used by the slice: KEY_EVT_REPEAT_EN
// -----------------------------------------------------------------------------
package key_evt_pkg;

  localparam int unsigned CNT_W = 26;

  // 1 s hold qualifies a long press
  localparam logic [CNT_W-1:0] LONG_CNT_DEF   = 26'd50_000_000;
  // 300 ms window after first release for the second press
  localparam logic [CNT_W-1:0] DCLICK_WIN_DEF = 26'd15_000_000;
  // 200 ms auto-repeat period
  localparam logic [CNT_W-1:0] REPEAT_CNT_DEF = 26'd10_000_000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS     = 3'd1,
    ST_LONG_HELD = 3'd2,
    ST_WAIT_2ND  = 3'd3,
    ST_PRESS2    = 3'd4
  } key_state_t;

endpackage : key_evt_pkg

// File: rtl/key_event_decoder_edge_det.sv
// -----------------------------------------------------------------------------
// key_edge_det
// Registers the debounced key level and derives press/release strobes.
// Key level convention: 1 = released, 0 = pressed.
// Ports:
//   clk        : system clock
//   rst        : synchronous active-high reset
//   i_key      : debounced key level
//   o_press    : high for the cycle a 1->0 transition is seen
//   o_release  : high for the cycle a 0->1 transition is seen
// Parameters:
//   RST_VAL    : reset value of the delayed key copy. 0 (the pressed level)
//                means a key held through reset yields no press strobe.
// -----------------------------------------------------------------------------
module key_edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key,
  output logic o_press,
  output logic o_release
);

  logic r_key_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_d <= RST_VAL;
    end else begin
      r_key_d <= i_key;
    end
  end

  assign o_press   =  r_key_d & ~i_key;
  assign o_release = ~r_key_d &  i_key;

endmodule : key_edge_det

// File: rtl/key_event_decoder.sv
// -----------------------------------------------------------------------------
// key_event_decoder
// Classifies debounced key activity into one-cycle event pulses:
// short press, long press, double click and (optionally) auto-repeat.
// Optional feature: define KEY_EVT_REPEAT_EN to enable auto-repeat while a
// long press is held; otherwise repeat_pulse is tied low.
// Ports:
//   clk          : system clock
//   rst          : synchronous active-high reset
//   key_filter   : debounced key level, 1 = released, 0 = pressed
//   short_pulse  : single short press (after double-click window expires)
//   long_pulse   : hold reached LONG_CNT
//   double_pulse : second release within the double-click window
//   repeat_pulse : auto-repeat tick while held after a long press
// Parameters (clk cycles):
//   LONG_CNT, DCLICK_WIN, REPEAT_CNT (REPEAT_CNT only with KEY_EVT_REPEAT_EN)
// -----------------------------------------------------------------------------
module key_event_decoder
  import key_evt_pkg::*;
#(
  parameter logic [CNT_W-1:0] LONG_CNT   = LONG_CNT_DEF,
  parameter logic [CNT_W-1:0] DCLICK_WIN = DCLICK_WIN_DEF,
  parameter logic [CNT_W-1:0] REPEAT_CNT = REPEAT_CNT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_filter,
  output logic short_pulse,
  output logic long_pulse,
  output logic double_pulse,
  output logic repeat_pulse
);

  // Terminal counts compared against the counter value before increment.
  localparam logic [CNT_W-1:0] LONG_LAST   = LONG_CNT   - CNT_W'(1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = DCLICK_WIN - CNT_W'(1);

  // A zero count would make the terminal value wrap to all ones.
  if (LONG_CNT == '0 || DCLICK_WIN == '0 || REPEAT_CNT == '0) begin : g_param_chk
    $fatal(1, "key_event_decoder: timing parameters must be non-zero");
  end

  logic w_press;
  logic w_release;

  key_edge_det #(
    .RST_VAL (1'b0)
  ) u_edge (
    .clk       (clk),
    .rst       (rst),
    .i_key     (key_filter),
    .o_press   (w_press),
    .o_release (w_release)
  );

  key_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_short;
  logic             r_long;
  logic             r_double;

`ifdef KEY_EVT_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = REPEAT_CNT - CNT_W'(1);
  logic             r_repeat;
`endif

  // Edge checks are placed ahead of terminal-count checks so that a
  // simultaneous edge wins: release beats long in PRESS, press beats the
  // short timeout in WAIT_2ND, release beats a repeat tick in LONG_HELD.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_double <= 1'b0;
`ifdef KEY_EVT_REPEAT_EN
      r_repeat <= 1'b0;
`endif
    end else begin
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_double <= 1'b0;
`ifdef KEY_EVT_REPEAT_EN
      r_repeat <= 1'b0;
`endif
      unique case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_press) begin
            r_state <= ST_PRESS;
          end
        end

        ST_PRESS: begin
          if (w_release) begin
            r_state <= ST_WAIT_2ND;
            r_cnt   <= '0;
          end else if (r_cnt == LONG_LAST) begin
            r_long  <= 1'b1;
            r_state <= ST_LONG_HELD;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_LONG_HELD: begin
          if (w_release) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
`ifdef KEY_EVT_REPEAT_EN
          end else if (r_cnt == REPEAT_LAST) begin
            r_repeat <= 1'b1;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
`else
          end
`endif
        end

        ST_WAIT_2ND: begin
          if (w_press) begin
            r_state <= ST_PRESS2;
            r_cnt   <= '0;
          end else if (r_cnt == DCLICK_LAST) begin
            r_short <= 1'b1;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_PRESS2: begin
          r_cnt <= '0;
          if (w_release) begin
            r_double <= 1'b1;
            r_state  <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign short_pulse  = r_short;
  assign long_pulse   = r_long;
  assign double_pulse = r_double;
`ifdef KEY_EVT_REPEAT_EN
  assign repeat_pulse = r_repeat;
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule : key_event_decoder

// File: tb/tb_key_event_decoder.sv
// Self-checking bench for key_event_decoder with short timing parameters.
// Pulse vectors are packed as {short, long, double, repeat}.
module tb_key_event_decoder;

  localparam int LONG = 20;
  localparam int DCLK = 10;
  localparam int REP  = 8;
  localparam int MAXN = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_filter = 1'b1;
  logic short_pulse, long_pulse, double_pulse, repeat_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  logic       wave [MAXN];
  logic       pe   [MAXN];
  logic       re   [MAXN];
  logic [3:0] expv [MAXN];
  logic [3:0] obsv [MAXN];
  int         wlen;

  always #5 clk = ~clk;

  key_event_decoder #(
    .LONG_CNT   (26'd20),
    .DCLICK_WIN (26'd10),
    .REPEAT_CNT (26'd8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_filter   (key_filter),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .double_pulse (double_pulse),
    .repeat_pulse (repeat_pulse)
  );

  function automatic logic [3:0] pulses();
    return {short_pulse, long_pulse, double_pulse, repeat_pulse};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    key_filter = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_wave();
    wlen = 0;
  endtask

  task automatic add_seg(input logic lvl, input int len);
    for (int i = 0; i < len; i++) begin
      wave[wlen] = lvl;
      wlen++;
    end
  endtask

  // Index of the first press (or release) edge at or after 'from'; wlen if none.
  function automatic int next_edge(input logic want_press, input int from);
    for (int i = from; i < wlen; i++) begin
      if (want_press ? pe[i] : re[i]) return i;
    end
    return wlen;
  endfunction

  // Reference model: locate press/release edge times, then place pulses by
  // timing rules. Index i is the i-th rising clock edge after reset release.
  task automatic build_expected();
    logic kd;
    int n, p, r, p2, r2;
    kd = 1'b0;
    for (int i = 0; i < wlen; i++) begin
      pe[i]   = kd & ~wave[i];
      re[i]   = ~kd & wave[i];
      kd      = wave[i];
      expv[i] = 4'b0000;
    end
    n = 0;
    while (n < wlen) begin
      p = next_edge(1'b1, n);
      if (p >= wlen) break;
      r = next_edge(1'b0, p + 1);
      if (r > p + LONG) begin
        if (p + LONG < wlen) expv[p + LONG][2] = 1'b1;
`ifdef KEY_EVT_REPEAT_EN
        for (int t = p + LONG + REP; t < r && t < wlen; t += REP) expv[t][0] = 1'b1;
`endif
        n = r + 1;
      end else begin
        p2 = next_edge(1'b1, r + 1);
        if (p2 <= r + DCLK) begin
          r2 = next_edge(1'b0, p2 + 1);
          if (r2 < wlen) expv[r2][1] = 1'b1;
          n = r2 + 1;
        end else begin
          if (r + DCLK < wlen) expv[r + DCLK][3] = 1'b1;
          n = r + DCLK + 1;
        end
      end
    end
  endtask

  // Starts just after do_reset (at a falling edge); samples 1 time unit after
  // each rising edge.
  task automatic run_wave();
    for (int i = 0; i < wlen; i++) begin
      key_filter = wave[i];
      @(posedge clk);
      #1;
      obsv[i] = pulses();
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    key_filter = 1'b0;
    repeat (4) @(negedge clk);
    key_filter = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (pulses() !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 0000", pulses());
    end
  endtask

  task automatic test_short();
    do_reset();
    clear_wave();
    add_seg(1'b1, 3); add_seg(1'b0, 5); add_seg(1'b1, 20);
    build_expected();
    run_wave();
    n_cmp++;
    if (obsv[18] !== 4'b1000) begin
      n_bad++;
      $display("FAIL short_timing: got %b want 1000 at cycle 18", obsv[18]);
    end
    for (int i = 0; i < wlen; i++) begin
      n_cmp++;
      if (obsv[i] !== expv[i]) begin
        n_bad++;
        $display("FAIL short cycle %0d: got %b want %b", i, obsv[i], expv[i]);
      end
    end
  endtask

  task automatic test_long();
    do_reset();
    clear_wave();
    add_seg(1'b1, 3); add_seg(1'b0, 30); add_seg(1'b1, 20);
    build_expected();
    run_wave();
    n_cmp++;
    if (obsv[23] !== 4'b0100) begin
      n_bad++;
      $display("FAIL long_timing: got %b want 0100 at cycle 23", obsv[23]);
    end
    for (int i = 0; i < wlen; i++) begin
      n_cmp++;
      if (obsv[i] !== expv[i]) begin
        n_bad++;
        $display("FAIL long cycle %0d: got %b want %b", i, obsv[i], expv[i]);
      end
    end
  endtask

  task automatic test_double();
    do_reset();
    clear_wave();
    add_seg(1'b1, 3); add_seg(1'b0, 5); add_seg(1'b1, 4); add_seg(1'b0, 3); add_seg(1'b1, 20);
    build_expected();
    run_wave();
    n_cmp++;
    if (obsv[15] !== 4'b0010) begin
      n_bad++;
      $display("FAIL double_timing: got %b want 0010 at cycle 15", obsv[15]);
    end
    for (int i = 0; i < wlen; i++) begin
      n_cmp++;
      if (obsv[i] !== expv[i]) begin
        n_bad++;
        $display("FAIL double cycle %0d: got %b want %b", i, obsv[i], expv[i]);
      end
    end
  endtask

  // Second press lands on the last cycle of the window (counter at 9).
  task automatic test_dclick_boundary();
    do_reset();
    clear_wave();
    add_seg(1'b1, 3); add_seg(1'b0, 5); add_seg(1'b1, 10); add_seg(1'b0, 3); add_seg(1'b1, 20);
    build_expected();
    run_wave();
    n_cmp++;
    if (obsv[18] !== 4'b0000 || obsv[21] !== 4'b0010) begin
      n_bad++;
      $display("FAIL dclick_boundary: got %b/%b want 0000/0010 at cycles 18/21",
               obsv[18], obsv[21]);
    end
    for (int i = 0; i < wlen; i++) begin
      n_cmp++;
      if (obsv[i] !== expv[i]) begin
        n_bad++;
        $display("FAIL dclick_boundary cycle %0d: got %b want %b", i, obsv[i], expv[i]);
      end
    end
  endtask

  // Release on exactly the cycle the long count would complete: short path.
  task automatic test_long_boundary();
    do_reset();
    clear_wave();
    add_seg(1'b1, 3); add_seg(1'b0, 20); add_seg(1'b1, 20);
    build_expected();
    run_wave();
    n_cmp++;
    if (obsv[23] !== 4'b0000 || obsv[33] !== 4'b1000) begin
      n_bad++;
      $display("FAIL long_boundary: got %b/%b want 0000/1000 at cycles 23/33",
               obsv[23], obsv[33]);
    end
    for (int i = 0; i < wlen; i++) begin
      n_cmp++;
      if (obsv[i] !== expv[i]) begin
        n_bad++;
        $display("FAIL long_boundary cycle %0d: got %b want %b", i, obsv[i], expv[i]);
      end
    end
  endtask

  task automatic test_repeat();
    do_reset();
    clear_wave();
    add_seg(1'b1, 3); add_seg(1'b0, 50); add_seg(1'b1, 20);
    build_expected();
    run_wave();
`ifdef KEY_EVT_REPEAT_EN
    n_cmp++;
    if (obsv[31] !== 4'b0001 || obsv[39] !== 4'b0001 || obsv[47] !== 4'b0001) begin
      n_bad++;
      $display("FAIL repeat_timing: got %b/%b/%b want 0001 at cycles 31/39/47",
               obsv[31], obsv[39], obsv[47]);
    end
`endif
    for (int i = 0; i < wlen; i++) begin
      n_cmp++;
      if (obsv[i] !== expv[i]) begin
        n_bad++;
        $display("FAIL repeat cycle %0d: got %b want %b", i, obsv[i], expv[i]);
      end
    end
  endtask

  // Reset during WAIT_2ND with the key pressed across deassertion: no events.
  task automatic test_reset_mid();
    do_reset();
    clear_wave();
    add_seg(1'b1, 3); add_seg(1'b0, 5); add_seg(1'b1, 3);
    run_wave();
    for (int i = 0; i < wlen; i++) begin
      n_cmp++;
      if (obsv[i] !== 4'b0000) begin
        n_bad++;
        $display("FAIL reset_mid pre cycle %0d: got %b want 0000", i, obsv[i]);
      end
    end
    rst = 1'b1;
    key_filter = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      key_filter = (i < 5) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      n_cmp++;
      if (pulses() !== 4'b0000) begin
        n_bad++;
        $display("FAIL reset_mid post cycle %0d: got %b want 0000", i, pulses());
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    for (int round = 0; round < 4; round++) begin
      do_reset();
      clear_wave();
      add_seg(1'b1, 2);
      while (wlen < 500) begin
        add_seg(1'b0, int'($urandom_range(1, 45)));
        add_seg(1'b1, int'($urandom_range(1, 14)));
      end
      add_seg(1'b1, 40);
      build_expected();
      run_wave();
      for (int i = 0; i < wlen; i++) begin
        n_cmp++;
        if (obsv[i] !== expv[i]) begin
          n_bad++;
          $display("FAIL random r%0d cycle %0d: got %b want %b", round, i, obsv[i], expv[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_double();
    test_dclick_boundary();
    test_long_boundary();
    test_repeat();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_key_event_decoder
